// File: rtl/cross_bar_pkg.sv
// ============================================================================
// cross_bar_pkg : shared types and default widths for the cross-bar switch
// Revision      : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package cross_bar_pkg;

  localparam int DEF_SSEL_WIDTH     = 2;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_DROP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } route_state_t;

endpackage

`default_nettype wire

// File: rtl/cross_bar_skid_buffer.sv
// ============================================================================
// cross_bar_skid_buffer : 2-entry AXI-S register slice carrying {data, last, dest}
// Revision              : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cross_bar_skid_buffer
  import cross_bar_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEST_WIDTH = DEF_SSEL_WIDTH
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic [DEST_WIDTH-1:0] s_dest,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [DEST_WIDTH-1:0] m_dest
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + 1 + DEST_WIDTH;

  logic [ENTRY_WIDTH-1:0] main_q, main_d;
  logic [ENTRY_WIDTH-1:0] skid_q, skid_d;
  logic                   main_valid_q, main_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic                   ready_q, ready_d;
  logic [ENTRY_WIDTH-1:0] s_entry;
  logic                   push;
  logic                   drain;

  assign s_entry = {s_data, s_last, s_dest};
  assign push    = s_valid && ready_q;
  assign drain   = main_valid_q && m_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || drain) begin
      // Skid always holds the older beat, so it refills main first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_d       = s_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_d       = s_entry;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready                  = ready_q;
  assign m_valid                  = main_valid_q;
  assign {m_data, m_last, m_dest} = main_q;

endmodule

`default_nettype wire

// File: rtl/cross_bar_router_1xn.sv
// ============================================================================
// cross_bar_router_1xn : packet-locked 1-to-N AXI-S router with invalid-dest drop
// Revision             : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cross_bar_router_1xn
  import cross_bar_pkg::*;
#(
  parameter int SSEL_WIDTH     = DEF_SSEL_WIDTH,
  parameter int CHANNEL_NO     = 2**SSEL_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  input  logic [SSEL_WIDTH-1:0]     s_axis_tdest,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata [CHANNEL_NO],
  output logic [CHANNEL_NO-1:0]     m_axis_tvalid,
  output logic [CHANNEL_NO-1:0]     m_axis_tlast,
  input  logic [CHANNEL_NO-1:0]     m_axis_tready,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam logic [SSEL_WIDTH:0]     DEST_LIMIT = (SSEL_WIDTH+1)'(CHANNEL_NO);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);

  route_state_t              state_q, state_d;
  logic [SSEL_WIDTH-1:0]     cur_dest_q, cur_dest_d;
  logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic                  accept;
  logic                  dest_ok;
  logic                  route_valid;
  logic [SSEL_WIDTH-1:0] route_dest;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [SSEL_WIDTH-1:0] out_dest;

  assign accept  = s_axis_tvalid && s_axis_tready;
  assign dest_ok = {1'b0, s_axis_tdest} < DEST_LIMIT;

  always_comb begin
    state_d      = state_q;
    cur_dest_d   = cur_dest_q;
    drop_count_d = drop_count_q;
    route_valid  = 1'b0;
    route_dest   = cur_dest_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dest_ok) begin
            route_valid = 1'b1;
            route_dest  = s_axis_tdest;
            cur_dest_d  = s_axis_tdest;
            state_d     = s_axis_tlast ? IDLE : ACTIVE;
          end else begin
            if (drop_count_q != '1) begin
              drop_count_d = drop_count_q + DROP_ONE;
            end
            state_d = s_axis_tlast ? IDLE : DROP;
          end
        end
      end
      ACTIVE: begin
        if (accept) begin
          route_valid = 1'b1;
          if (s_axis_tlast) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      cur_dest_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_dest_q   <= cur_dest_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Dropped beats never enter the slice, but ingress ready still comes from it.
  cross_bar_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEST_WIDTH (SSEL_WIDTH)
  ) u_skid (
    .aclk    (aclk),
    .areset  (areset),
    .s_valid (route_valid),
    .s_ready (s_axis_tready),
    .s_data  (s_axis_tdata),
    .s_last  (s_axis_tlast),
    .s_dest  (route_dest),
    .m_valid (out_valid),
    .m_ready (out_ready),
    .m_data  (out_data),
    .m_last  (out_last),
    .m_dest  (out_dest)
  );

  assign out_ready  = |(m_axis_tvalid & m_axis_tready);
  assign drop_count = drop_count_q;

  for (genvar i = 0; i < CHANNEL_NO; i++) begin : g_chan
    localparam logic [SSEL_WIDTH-1:0] CH_ID = SSEL_WIDTH'(i);
    assign m_axis_tvalid[i] = out_valid && (out_dest == CH_ID);
    assign m_axis_tdata[i]  = out_data;
    assign m_axis_tlast[i]  = out_last;
  end

endmodule

`default_nettype wire

// File: doc/cross_bar_router_1xn.md
Name: cross_bar_router_1xn

Overview:
- Upstream stage of the MxN cross-bar switch.
- Takes one AXI-Stream ingress port and steers each packet, using s_axis_tdest, to one of CHANNEL_NO egress streams.
- Each egress stream feeds one input of a per-output Mx1 arbiter.
- Routing is packet-locked: the destination is captured on the first beat and held until tlast.
- The output stage is a registered skid buffer: full throughput, 1-cycle latency.

Parameters:
- SSEL_WIDTH, 2, width of s_axis_tdest.
- CHANNEL_NO, 2**SSEL_WIDTH, number of egress streams (1..2**SSEL_WIDTH).
- DATA_WIDTH, 32, tdata width.
- DROP_CNT_WIDTH, 16, width of the dropped-packet counter.

Ports:
- aclk  input  1  clock; all logic on its rising edge.
- areset  input  1  reset; synchronous, active-high.
- s_axis_tdata  input  DATA_WIDTH  ingress data.
- s_axis_tvalid  input  1  ingress valid.
- s_axis_tlast  input  1  ingress end of packet.
- s_axis_tdest  input  SSEL_WIDTH  destination; sampled only on the first beat of a packet.
- s_axis_tready  output  1  ingress ready; driven directly from a register.
- m_axis_tdata  output  DATA_WIDTH x [CHANNEL_NO]  egress data; the same value is broadcast to every channel.
- m_axis_tvalid  output  1 x [CHANNEL_NO]  egress valid; at most one bit set.
- m_axis_tlast  output  1 x [CHANNEL_NO]  egress last; broadcast to every channel.
- m_axis_tready  input  1 x [CHANNEL_NO]  egress ready, per channel.
- drop_count  output  DROP_CNT_WIDTH  number of packets discarded for an invalid destination; saturates.

Behaviour:
- Reset values (areset=1 at a rising edge):
  - state=IDLE; main and skid registers empty.
  - all m_axis_tvalid=0; s_axis_tready=1; drop_count=0; m_axis_tdata/tlast=0.
- Ingress accept occurs when s_axis_tvalid && s_axis_tready.
- Route state machine, advanced on each accepted beat:
  - IDLE, tdest<CHANNEL_NO: latch cur_dest=tdest. Beat goes to the output stage. Next state is ACTIVE, or stays IDLE if tlast=1 (single-beat packet).
  - IDLE, tdest>=CHANNEL_NO: beat is discarded and drop_count increments now. Next state is DROP, or stays IDLE if tlast=1.
  - ACTIVE: beat goes to cur_dest; tdest is ignored. On tlast, return to IDLE.
  - DROP: beat is discarded with no output and no counter change. On tlast, return to IDLE.
  - Undefined encoding: return to IDLE.
- Output stage (main register plus one skid register; each holds {data, last, dest}):
  - m_axis_tvalid[i] = main_valid && main_dest==i.
  - Egress handshake on channel i: m_axis_tvalid[i] && m_axis_tready[i].
  - Main empty, or draining this cycle: a routed beat loads main.
  - Otherwise: a routed beat loads skid, and s_axis_tready drops to 0 on the next cycle.
  - When main drains and skid is full: skid moves to main and s_axis_tready returns to 1 on the next cycle.
  - Latency: a beat accepted at edge t is visible on m_axis at t+1.
  - Sustained throughput is 1 beat/clk while the selected m_axis_tready=1.
- Handshake rules:
  - m_axis_tvalid, once asserted, stays high with tdata/tlast stable until the handshake completes.
  - Never raise tvalid on two channels at once.
  - Ready on a non-selected channel has no effect.
- Ordering:
  - Beats leave in acceptance order.
  - A new packet to a different dest may sit in skid while the previous packet's last beat waits in main; no reordering is permitted.
- Discarded beats still take ingress ready. s_axis_tready is unaffected by DROP, so a dropped packet drains at 1 beat/clk.
- drop_count saturates at all-ones and does not wrap.
- If CHANNEL_NO==2**SSEL_WIDTH, DROP is unreachable.
- Reset mid-packet: all buffered beats are lost, state returns to IDLE, and the next accepted beat is treated as a first beat. The downstream arbiter shares areset.
- tdest changing mid-packet has no effect.

Decomposition:
- Package cross_bar_pkg:
  - route_state_t enum {IDLE, ACTIVE, DROP}, shared with the arbiter's state type.
  - Default-width localparams.
- One sub-module: cross_bar_skid_buffer, a generic 2-entry AXI-S register slice carrying {tdata, tlast, dest}. The arbiter output stage reuses it later.
- The route FSM and drop counter live in the top module.

Test Plan:
- Reset then idle -> s_axis_tready=1, all m_axis_tvalid=0, drop_count=0.
- 4-beat packet, tdest=2, tdata 0xA0..0xA3, all readies=1 -> m_axis_tvalid[2] high on cycles t+1..t+4 with 0xA0..0xA3, tlast on 0xA3, no other channel valid.
- tdest changed to 1 on beats 2-3 of a 3-beat packet to dest 3 -> all beats on channel 3. A following 1-beat packet with tdest=1 -> channel 1.
- m_axis_tready[0]=0 for 5 cycles during a packet to dest 0 -> s_axis_tready falls 1 cycle after skid fills. No beat lost or duplicated; order preserved after release.
- CHANNEL_NO=3, SSEL_WIDTH=2, 2-beat packet with tdest=3, then 1-beat packet with tdest=0 -> no egress for the first packet, drop_count=1, second packet on channel 0.
- areset asserted mid-packet with main and skid full -> next cycle all m_axis_tvalid=0, s_axis_tready=1. A new packet routes by its own first-beat tdest.
